scr1_ahb_sram_slave: RTL and testbench



---
 rtl/scr1_ahb_sram_slave_pkg.sv | 30 +++
 rtl/scr1_ahb_slave_bemask.sv | 34 +++
 rtl/scr1_ahb_sram_slave.sv | 153 +++++++++++++++
 tb/tb_scr1_ahb_sram_slave.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_ahb_sram_slave_pkg.sv
// rtl/scr1_ahb_sram_slave_pkg.sv - AHB-Lite encodings and SRAM slave state type
package scr1_ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_slv_state_e;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are answered with zero-wait OKAY
    function automatic logic htrans_is_active(input logic [1:0] trans);
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scr1_ahb_slave_bemask.sv
// rtl/scr1_ahb_slave_bemask.sv - byte-enable and misalignment decode from hsize and addr[1:0]
module scr1_ahb_slave_bemask
    import scr1_ahb_sram_slave_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output logic [3:0] be_o,
    output logic       misalign_o
);

    // Little-endian lane select; sizes above word give no lanes and are rejected by the caller
    always_comb begin
        be_o       = 4'b0000;
        misalign_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: begin
                be_o = 4'b0001 << addr_i;
            end
            HSIZE_HALF: begin
                be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_i[0];
            end
            HSIZE_WORD: begin
                be_o       = 4'b1111;
                misalign_o = (addr_i != 2'b00);
            end
            default: begin
                be_o       = 4'b0000;
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/scr1_ahb_sram_slave.sv
// rtl/scr1_ahb_sram_slave.sv - AHB-Lite SRAM slave with programmable wait states and ERROR response
module scr1_ahb_sram_slave
    import scr1_ahb_sram_slave_pkg::*;
#(
    parameter int MEM_POWER_SIZE = 16,
    parameter int AHB_WIDTH      = 32,
    parameter int STALL_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall_cfg,
    input  logic [1:0]           htrans,
    input  logic [AHB_WIDTH-1:0] haddr,
    input  logic [2:0]           hsize,
    input  logic                 hwrite,
    input  logic [AHB_WIDTH-1:0] hwdata,
    output logic                 hready,
    output logic [AHB_WIDTH-1:0] hrdata,
    output logic                 hresp
);

    localparam int IDX_W = MEM_POWER_SIZE - 2;
    localparam int DEPTH = 1 << IDX_W;

    ahb_slv_state_e       state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [3:0]           be_q;
    logic                 write_q;
    logic                 legal_q;
    logic [STALL_W-1:0]   cnt_q;
    logic                 hready_q;
    logic                 hresp_q;
    logic [AHB_WIDTH-1:0] hrdata_q;
    logic [AHB_WIDTH-1:0] hrdata_d;

    logic [AHB_WIDTH-1:0] mem [DEPTH];

    logic                 accept;
    logic                 in_range;
    logic                 misalign;
    logic                 legal;
    logic                 commit_we;
    logic [3:0]           be_addr;
    logic [IDX_W-1:0]     rd_idx;

    scr1_ahb_slave_bemask u_bemask (
        .hsize_i    (hsize),
        .addr_i     (haddr[1:0]),
        .be_o       (be_addr),
        .misalign_o (misalign)
    );

    // Address-phase decode: a transfer is taken only when the bus is ready and it is NONSEQ/SEQ
    always_comb begin
        accept    = hready_q && htrans_is_active(htrans);
        in_range  = (haddr[AHB_WIDTH-1:MEM_POWER_SIZE] == '0);
        legal     = in_range && !misalign && (hsize <= HSIZE_WORD);
        commit_we = (state_q == ST_DATA) && write_q && legal_q;
    end

    // Next read word, merging a write that commits on the same edge so back-to-back reads see it
    always_comb begin
        rd_idx   = (state_q == ST_WAIT) ? idx_q : haddr[MEM_POWER_SIZE-1:2];
        hrdata_d = mem[rd_idx];
        if (commit_we && (rd_idx == idx_q)) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    hrdata_d[8*b +: 8] = hwdata[8*b +: 8];
                end
            end
        end
    end

    // Write lanes land on the edge that closes DATA; a reset on that edge drops the write
    always_ff @(posedge clk) begin
        if (commit_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    // Transfer FSM with registered hready/hresp/hrdata; IDLE, DATA and ERR2 all accept new transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            be_q     <= '0;
            write_q  <= 1'b0;
            legal_q  <= 1'b0;
            cnt_q    <= '0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == STALL_W'(1)) begin
                        state_q  <= ST_DATA;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                        if (!write_q) begin
                            hrdata_q <= hrdata_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - STALL_W'(1);
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        idx_q   <= haddr[MEM_POWER_SIZE-1:2];
                        be_q    <= be_addr;
                        write_q <= hwrite;
                        legal_q <= legal;
                        cnt_q   <= stall_cfg;
                        if (!legal) begin
                            state_q  <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b1;
                        end else if (stall_cfg == '0) begin
                            state_q  <= ST_DATA;
                            hready_q <= 1'b1;
                            hresp_q  <= 1'b0;
                            if (!hwrite) begin
                                hrdata_q <= hrdata_d;
                            end
                        end else begin
                            state_q  <= ST_WAIT;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b0;
                        end
                    end else begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign hready = hready_q;
    assign hresp  = hresp_q;
    assign hrdata = hrdata_q;

endmodule

// File: tb/tb_scr1_ahb_sram_slave.sv
// tb/tb_scr1_ahb_sram_slave.sv - randomized self-checking bench for scr1_ahb_sram_slave
module tb_scr1_ahb_sram_slave;

    localparam int         MPS    = 16;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  stall_cfg;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;

    always #5 clk = ~clk;

    scr1_ahb_sram_slave #(
        .MEM_POWER_SIZE (MPS),
        .AHB_WIDTH      (32),
        .STALL_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall_cfg (stall_cfg),
        .htrans    (htrans),
        .haddr     (haddr),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata),
        .hresp     (hresp)
    );

    typedef struct packed {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic [7:0]  stall;
    } xfer_t;

    xfer_t       q[$];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;
    bit          abort  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal_of(input logic [31:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b0;
        if ((a % (32'd1 << sz)) != 32'd0) return 1'b0;
        if (a >= 32'h0001_0000) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        w = int'(a & 32'h0000_FFFC);
        return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int n;
        int lane;
        n = 1 << sz;
        for (int k = 0; k < n; k++) begin
            lane = int'((a + k) % 4);
            ref_mem[int'(a) + k] = d[8*lane +: 8];
        end
    endtask

    task automatic push(input logic [1:0] t, input logic [31:0] a, input logic [2:0] s,
                        input logic w, input logic [31:0] d, input logic [7:0] st);
        xfer_t x;
        x.trans = t; x.addr = a; x.size = s; x.wr = w; x.wdata = d; x.stall = st;
        q.push_back(x);
    endtask

    task automatic drive_addr(input xfer_t x);
        htrans    = x.trans;
        haddr     = x.addr;
        hsize     = x.size;
        hwrite    = x.wr;
        stall_cfg = x.stall;
    endtask

    task automatic drive_idle();
        htrans    = T_IDLE;
        haddr     = $urandom;
        hsize     = 3'($urandom_range(0, 7));
        hwrite    = 1'($urandom_range(0, 1));
        stall_cfg = 8'($urandom);
    endtask

    // Called at a negedge with the bus ready; leaves the bus idle at the final negedge
    task automatic run_queue();
        xfer_t       cur;
        int          cycles;
        int          bad_wait;
        logic        first_resp;
        bit          active;
        bit          ok;
        logic [31:0] exp_rd;
        if (q.size() == 0) return;
        drive_addr(q[0]);
        for (int i = 0; i < q.size(); i++) begin
            cur = q[i];
            @(negedge clk);
            hwdata     = cur.wdata;
            cycles     = 1;
            bad_wait   = 0;
            first_resp = hresp;
            while (!hready && cycles < 64) begin
                if (hresp) bad_wait++;
                stall_cfg = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
                @(negedge clk);
                cycles++;
            end
            if (!hready) begin
                chk("timeout", 32'(hready), 32'd1);
                abort = 1;
                q.delete();
                return;
            end
            active = cur.trans[1];
            ok     = active && legal_of(cur.addr, cur.size);
            if (!active) begin
                chk("idle_lat", 32'(cycles), 32'd1);
                chk("idle_resp", 32'(hresp), 32'd0);
            end else if (!ok) begin
                chk("err_lat", 32'(cycles), 32'd2);
                chk("err_first", 32'(first_resp), 32'd1);
                chk("err_resp", 32'(hresp), 32'd1);
            end else begin
                chk("lat", 32'(cycles), 32'(cur.stall) + 32'd1);
                chk("resp", 32'(hresp), 32'd0);
                if (cur.stall != 8'd0) chk("wait_resp", 32'(bad_wait), 32'd0);
            end
            exp_rd = (ok && !cur.wr) ? model_read(cur.addr) : last_rd;
            chk("rdata", hrdata, exp_rd);
            last_rd = exp_rd;
            if (ok && cur.wr) model_write(cur.addr, cur.size, cur.wdata);
            if (i + 1 < q.size()) drive_addr(q[i+1]);
            else drive_idle();
        end
        q.delete();
    endtask

    task automatic gen_random(input int n);
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  t;
        logic [7:0]  st;
        int          r;
        for (int k = 0; k < n; k++) begin
            r  = $urandom_range(0, 99);
            t  = (r < 4) ? T_IDLE : (r < 8) ? T_BUSY : (r < 60) ? T_NSEQ : T_SEQ;
            sz = ($urandom_range(0, 99) < 5) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if (sz <= 3'd2 && $urandom_range(0, 9) < 8) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 99) < 3) a = a | (32'($urandom_range(1, 65535)) << 16);
            r  = $urandom_range(0, 9);
            st = (r < 6) ? 8'd0 : 8'($urandom_range(1, (r == 9) ? 6 : 3));
            push(t, a, sz, 1'($urandom_range(0, 1)), $urandom, st);
        end
    endtask

    initial begin
        rst = 1'b1; htrans = T_IDLE; haddr = '0; hsize = '0; hwrite = 1'b0;
        hwdata = '0; stall_cfg = '0; last_rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_hready", 32'(hready), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // word write then word read, zero wait
        push(T_NSEQ, 32'h100, 3'd2, 1'b1, 32'hDEADBEEF, 8'd0);
        push(T_NSEQ, 32'h100, 3'd2, 1'b0, 32'h0, 8'd0);
        run_queue();
        chk("plan_wr_rd", hrdata, 32'hDEADBEEF);

        // three wait states; stall_cfg is scrambled during the wait
        if (!abort) begin
            push(T_NSEQ, 32'h100, 3'd2, 1'b0, 32'h0, 8'd3);
            run_queue();
            chk("plan_stall3", hrdata, 32'hDEADBEEF);
        end

        // byte and halfword writes followed immediately by a read
        if (!abort) begin
            push(T_NSEQ, 32'h102, 3'd0, 1'b1, 32'h1155_2233, 8'd0);
            push(T_SEQ,  32'h100, 3'd1, 1'b1, 32'h9999_AABB, 8'd0);
            push(T_NSEQ, 32'h100, 3'd2, 1'b0, 32'h0, 8'd0);
            run_queue();
            chk("plan_merge", hrdata, 32'hDE55AABB);
        end

        // illegal writes leave memory untouched
        if (!abort) begin
            push(T_NSEQ, 32'h101, 3'd2, 1'b1, 32'hFFFF_FFFF, 8'd0);
            push(T_NSEQ, 32'h100, 3'd3, 1'b1, 32'hFFFF_FFFF, 8'd2);
            push(T_NSEQ, 32'h1_0000, 3'd2, 1'b1, 32'hFFFF_FFFF, 8'd0);
            push(T_NSEQ, 32'h100, 3'd2, 1'b0, 32'h0, 8'd0);
            run_queue();
            chk("plan_err_keep", hrdata, 32'hDE55AABB);
        end

        // reset in the middle of a stalled write
        if (!abort) begin
            htrans = T_NSEQ; haddr = 32'h100; hsize = 3'd2; hwrite = 1'b1; stall_cfg = 8'd5;
            @(negedge clk);
            hwdata = 32'h1234_5678;
            chk("rst_mid_wait", 32'(hready), 32'd0);
            @(negedge clk);
            htrans = T_IDLE;
            rst    = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_mid_hready", 32'(hready), 32'd1);
            chk("rst_mid_hresp", 32'(hresp), 32'd0);
            chk("rst_mid_hrdata", hrdata, 32'd0);
            last_rd = '0;
            @(negedge clk);
            chk("rst_idle_hready", 32'(hready), 32'd1);
            push(T_NSEQ, 32'h100, 3'd2, 1'b0, 32'h0, 8'd1);
            run_queue();
            chk("plan_rst_keep", hrdata, 32'hDE55AABB);
        end

        // IDLE/BUSY interleaved with real transfers
        if (!abort) begin
            push(T_IDLE, 32'h100, 3'd2, 1'b1, 32'h0, 8'd4);
            push(T_BUSY, 32'h100, 3'd2, 1'b1, 32'h0, 8'd4);
            push(T_NSEQ, 32'h100, 3'd2, 1'b0, 32'h0, 8'd0);
            push(T_BUSY, 32'h104, 3'd2, 1'b1, 32'h0, 8'd2);
            push(T_NSEQ, 32'h104, 3'd2, 1'b1, 32'hCAFE_F00D, 8'd2);
            push(T_IDLE, 32'h104, 3'd2, 1'b0, 32'h0, 8'd0);
            push(T_NSEQ, 32'h104, 3'd2, 1'b0, 32'h0, 8'd0);
            run_queue();
            chk("plan_idle_mix", hrdata, 32'hCAFE_F00D);
        end

        // prefill the random region, then 10k random transfers
        if (!abort) begin
            for (int w = 0; w < 64; w++) push(T_NSEQ, 32'(w * 4), 3'd2, 1'b1, $urandom, 8'd0);
            run_queue();
        end
        for (int c = 0; c < 100 && !abort; c++) begin
            gen_random(100);
            run_queue();
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
